// File: rtl/latex_chk_pkg.sv
// rtl/latex_chk_pkg.sv - shared state encodings and ASCII/CRC constants for the stream checker
package latex_chk_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CMP   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [7:0] ASCII_NUL    = 8'h00;
    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] CRC8_POLY    = 8'h07;

endpackage

// File: rtl/crc8_step.sv
// rtl/crc8_step.sv - one-byte combinational CRC-8 update (MSB-first, poly from package)
module crc8_step
    import latex_chk_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] w_c;

    always_comb begin
        w_c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[7] ? ((w_c << 1) ^ CRC8_POLY) : (w_c << 1);
        end
        crc_out = w_c;
    end

endmodule

// File: rtl/latex_stream_checker.sv
// rtl/latex_stream_checker.sv - compares a received byte stream against the character store
// Optional received-byte CRC-8 enabled by defining CRC_CHECK_EN.
module latex_stream_checker
    import latex_chk_pkg::*;
#(
    parameter int MAX_LEN = 200,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic              overflow,
    output logic [7:0]        err_pos,
    output logic [7:0]        char_count,
    output logic [7:0]        crc_out
);

    localparam logic [7:0] LP_MAX = 8'(MAX_LEN);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [7:0]        r_idx;
    logic [7:0]        r_exp;
    logic              r_match;
    logic              r_ovf;
    logic [7:0]        r_err_pos;
    logic [7:0]        r_count;

    logic       w_hs;
    logic [7:0] w_cnt_next;
    logic       w_hit_max;

    assign char_ready = (r_state == ST_CMP) || (r_state == ST_DRAIN);
    assign rd_en      = (r_state == ST_FETCH);
    assign rd_addr    = r_base + ADDR_W'(r_idx);
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign match      = r_match;
    assign overflow   = r_ovf;
    assign err_pos    = r_err_pos;
    assign char_count = r_count;

    assign w_hs       = char_valid && char_ready;
    assign w_cnt_next = r_count + 8'd1;
    assign w_hit_max  = (w_cnt_next == LP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_idx     <= '0;
            r_exp     <= '0;
            r_match   <= 1'b0;
            r_ovf     <= 1'b0;
            r_err_pos <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base    <= base_addr;
                        r_idx     <= '0;
                        r_match   <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_err_pos <= '0;
                        r_count   <= '0;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_WAIT;
                ST_WAIT: begin
                    r_exp   <= rd_data;
                    r_state <= ST_CMP;
                end
                ST_CMP: begin
                    if (w_hs) begin
                        r_count <= w_cnt_next;
                        if (char_in == r_exp) begin
                            if (r_exp == ASCII_NUL) begin
                                r_match <= 1'b1;
                                r_state <= ST_DONE;
                            end else if (w_hit_max) begin
                                r_ovf     <= 1'b1;
                                r_match   <= 1'b0;
                                r_err_pos <= r_idx;
                                r_state   <= ST_DONE;
                            end else begin
                                r_idx   <= r_idx + 8'd1;
                                r_state <= ST_FETCH;
                            end
                        end else begin
                            r_err_pos <= r_idx;
                            r_match   <= 1'b0;
                            if (char_in == ASCII_NUL) begin
                                r_state <= ST_DONE;
                            end else if (w_hit_max) begin
                                r_ovf   <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // err_pos already records the first mismatch; only the length can still end us early
                    if (w_hs) begin
                        r_count <= w_cnt_next;
                        if (char_in == ASCII_NUL) begin
                            r_state <= ST_DONE;
                        end else if (w_hit_max) begin
                            r_ovf   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CRC_CHECK_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_next;

    crc8_step u_crc8_step (
        .crc_in  (r_crc),
        .data_in (char_in),
        .crc_out (w_crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_crc <= '0;
        end else if (w_hs) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc_out = r_crc;
`else
    assign crc_out = 8'h00;
`endif

endmodule

// File: tb/tb_latex_stream_checker.sv
// tb/tb_latex_stream_checker.sv - directed self-checking bench for latex_stream_checker
module tb_latex_stream_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] base_addr;
    logic [7:0] char_in;
    logic       char_valid;

    logic       ready_a, rd_en_a, busy_a, done_a, match_a, ovf_a;
    logic [7:0] rd_addr_a, rd_data_a, err_a, cnt_a, crc_a;
    logic       ready_b, rd_en_b, busy_b, done_b, match_b, ovf_b;
    logic [7:0] rd_addr_b, rd_data_b, err_b, cnt_b, crc_b;

    logic [7:0] mem [0:255];
    logic [7:0] addr_log [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    latex_stream_checker #(.MAX_LEN(200), .ADDR_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr),
        .char_in(char_in), .char_valid(char_valid), .char_ready(ready_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .busy(busy_a), .done(done_a), .match(match_a), .overflow(ovf_a),
        .err_pos(err_a), .char_count(cnt_a), .crc_out(crc_a)
    );

    latex_stream_checker #(.MAX_LEN(4), .ADDR_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr),
        .char_in(char_in), .char_valid(char_valid), .char_ready(ready_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .busy(busy_b), .done(done_b), .match(match_b), .overflow(ovf_b),
        .err_pos(err_b), .char_count(cnt_b), .crc_out(crc_b)
    );

    always @(posedge clk) begin
        if (rd_en_a) begin
            rd_data_a <= mem[rd_addr_a];
            addr_log.push_back(rd_addr_a);
        end
        if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_str(input logic [7:0] addr, input string s);
        logic [7:0] a;
        for (int i = 0; i < s.len(); i++) begin
            a = addr + 8'(i);
            mem[a] = s[i];
        end
        a = addr + 8'(s.len());
        mem[a] = 8'h00;
    endtask

    task automatic do_start(input bit sel, input logic [7:0] base);
        @(posedge clk); #1;
        base_addr = base;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        int n = 0;
        char_in    = b;
        char_valid = 1'b1;
        while (!(sel ? ready_b : ready_a) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask

    task automatic send_str(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) send(sel, s[i]);
        send(sel, 8'h00);
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n = 0;
        while (!(sel ? done_b : done_a) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(sel ? done_b : done_a), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        base_addr = 8'h00; char_in = 8'h00; char_valid = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        load_str(8'h10, "$t$");
        load_str(8'hFE, "ab");
        load_str(8'h20, "123456789");
        load_str(8'h40, "abcdef");
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_ready", 32'(ready_a), 0);
        check("rst_rd_en", 32'(rd_en_a), 0);
        check("rst_match", 32'(match_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        check("rst_err_pos", 32'(err_a), 0);
        check("rst_count", 32'(cnt_a), 0);
        check("rst_crc", 32'(crc_a), 0);
        rst = 1'b0;

        // matching "$t$"
        do_start(1'b0, 8'h10);
        send_str(1'b0, "$t$");
        wait_done(1'b0, "t1_done");
        check("t1_match", 32'(match_a), 1);
        check("t1_count", 32'(cnt_a), 4);
        check("t1_err_pos", 32'(err_a), 0);

        // mismatch at index 1, remainder drained
        do_start(1'b0, 8'h10);
        send_str(1'b0, "$s$");
        wait_done(1'b0, "t2_done");
        check("t2_match", 32'(match_a), 0);
        check("t2_err_pos", 32'(err_a), 1);
        check("t2_count", 32'(cnt_a), 4);

        // address wrap
        addr_log.delete();
        do_start(1'b0, 8'hFE);
        send_str(1'b0, "ab");
        wait_done(1'b0, "t3_done");
        check("t3_match", 32'(match_a), 1);
        check("t3_nreads", 32'(addr_log.size()), 3);
        if (addr_log.size() == 3) begin
            check("t3_addr0", 32'(addr_log[0]), 32'hFE);
            check("t3_addr1", 32'(addr_log[1]), 32'hFF);
            check("t3_addr2", 32'(addr_log[2]), 32'h00);
        end

        // overflow with MAX_LEN=4
        do_start(1'b1, 8'h40);
        send(1'b1, "a"); send(1'b1, "b"); send(1'b1, "c"); send(1'b1, "d");
        wait_done(1'b1, "t4_done");
        check("t4_ovf", 32'(ovf_b), 1);
        check("t4_match", 32'(match_b), 0);
        check("t4_count", 32'(cnt_b), 4);
        check("t4_err_pos", 32'(err_b), 3);

        // stall in CMP then reset mid-check
        do_start(1'b0, 8'h10);
        cnt = 0;
        while (!ready_a && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready_a && busy_a && !rd_en_a) cnt++;
        end
        check("t5_stall_ready", 32'(cnt), 10);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_busy", 32'(busy_a), 0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_a) cnt++;
            @(posedge clk); #1;
        end
        check("t5_no_done", 32'(cnt), 0);

        // CRC over "123456789" + NUL, start during DONE ignored
        do_start(1'b0, 8'h20);
        for (int i = 1; i <= 9; i++) send(1'b0, 8'h30 + 8'(i));
`ifdef CRC_CHECK_EN
        check("t6_crc9", 32'(crc_a), 32'hF4);
`else
        check("t6_crc9", 32'(crc_a), 32'h00);
`endif
        send(1'b0, 8'h00);
        wait_done(1'b0, "t6_done");
        check("t6_match", 32'(match_a), 1);
        check("t6_count", 32'(cnt_a), 10);
        start_a = 1'b1;
        base_addr = 8'h10;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("t6_start_in_done", 32'(busy_a), 0);
`ifdef CRC_CHECK_EN
        check("t6_crc10", 32'(crc_a), 32'hC2);
`else
        check("t6_crc10", 32'(crc_a), 32'h00);
`endif
        check("t6_match_held", 32'(match_a), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
